// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 8-digit 7-segment scan driver.
package seg7_scan_driver_pkg;

   localparam int NUM_DIGITS = 8;

   // Both SEG and NA are active-low, so all-ones turns everything off.
   localparam logic [7:0] ALL_OFF = 8'hFF;

   // Active-low gfedcba patterns, indexed by nibble value (entry 0 is rightmost).
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU-side load bus and display pin bus of the 7-segment scan driver.
interface seg7_scan_driver_if;
   logic        load;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  en_in;
   logic [7:0]  SEG;
   logic [7:0]  NA;
   logic        pending;
   logic        frame_done;

   modport master (
      output load, data_in, dp_in, en_in,
      input  SEG, NA, pending, frame_done
   );

   modport slave (
      input  load, data_in, dp_in, en_in,
      output SEG, NA, pending, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver_hex7seg_decode.sv
// Combinational nibble to active-low 7-segment (gfedcba) decoder.
module hex7seg_decode
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = HEX7_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver with shadow/active registers
// committed at frame boundaries and an anode blank window per digit slot.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic               GlobalClock,
   input  logic               RST_N,
   seg7_scan_driver_if.slave  bus
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_p0;
   logic [2:0]       idx_p0;
   logic [31:0]      shadow_data, active_data;
   logic [7:0]       shadow_dp, active_dp;
   logic [7:0]       shadow_en, active_en;
   logic             pending_q, frame_done_q;
   logic [7:0]       seg_p1, na_p1;

   logic             slot_end, frame_end, blank;
   logic [3:0]       nibble;
   logic [6:0]       seg7;
   logic [7:0]       seg_d, na_d;

   assign slot_end  = (cnt_p0 == CNT_LAST);
   assign frame_end = slot_end && (idx_p0 == IDX_LAST);
   assign blank     = (32'(cnt_p0) < BLANK_CYCLES);
   assign nibble    = active_data[{idx_p0, 2'b00} +: 4];

   hex7seg_decode u_decode (
      .nibble (nibble),
      .seg    (seg7)
   );

   // Stage p0: prescaler, digit index and tear-free commit.
   always_ff @(posedge GlobalClock or negedge RST_N) begin
      if (!RST_N) begin
         cnt_p0       <= '0;
         idx_p0       <= '0;
         shadow_data  <= '0;
         shadow_dp    <= '0;
         shadow_en    <= '0;
         active_data  <= '0;
         active_dp    <= '0;
         active_en    <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_p0       <= slot_end ? '0 : cnt_p0 + 1'b1;
         frame_done_q <= frame_end;
         if (slot_end) idx_p0 <= idx_p0 + 1'b1;
         // Commit reads the pre-load shadow, so a coincident load waits a frame.
         if (frame_end && pending_q) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            active_en   <= shadow_en;
         end
         if (bus.load) begin
            shadow_data <= bus.data_in;
            shadow_dp   <= bus.dp_in;
            shadow_en   <= bus.en_in;
            pending_q   <= 1'b1;
         end else if (frame_end) begin
            pending_q   <= 1'b0;
         end
      end
   end

   always_comb begin
      na_d  = ALL_OFF;
      seg_d = ALL_OFF;
      if (!blank && active_en[idx_p0]) begin
         na_d  = ~(8'b1 << idx_p0);
         seg_d = {~active_dp[idx_p0], seg7};
      end
   end

   // Stage p1: registered pin outputs.
   always_ff @(posedge GlobalClock or negedge RST_N) begin
      if (!RST_N) begin
         seg_p1 <= ALL_OFF;
         na_p1  <= ALL_OFF;
      end else begin
         seg_p1 <= seg_d;
         na_p1  <= na_d;
      end
   end

   assign bus.SEG        = seg_p1;
   assign bus.NA         = na_p1;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a frame-position model and literal spot checks.
module tb_seg7_scan_driver;
   localparam int SD    = 4;
   localparam int BL    = 1;
   localparam int FRAME = SD * 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
      .GlobalClock (clk),
      .RST_N       (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Model: m_n counts clock edges since reset release; its position inside
   // the frame gives digit and slot phase directly.
   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          m_n;
   int          pc, pd;
   logic        at_boundary;
   logic [31:0] m_sh_d, m_ac_d;
   logic [7:0]  m_sh_dp, m_ac_dp, m_sh_en, m_ac_en;
   logic        m_pend;
   logic [7:0]  e_na, e_seg;
   logic        e_pend, e_fd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_pend = 0;
         m_sh_d = 0; m_ac_d = 0; m_sh_dp = 0; m_ac_dp = 0; m_sh_en = 0; m_ac_en = 0;
         e_na = 8'hFF; e_seg = 8'hFF; e_pend = 0; e_fd = 0;
      end else begin
         pc = m_n % SD;
         pd = (m_n / SD) % 8;
         at_boundary = ((m_n % FRAME) == FRAME - 1);
         if (pc < BL || !m_ac_en[pd]) begin
            e_na = 8'hFF; e_seg = 8'hFF;
         end else begin
            e_na  = 8'hFF ^ (8'd1 << pd);
            e_seg = {~m_ac_dp[pd], hex_tab[m_ac_d[pd*4 +: 4]]};
         end
         e_fd = at_boundary;
         if (at_boundary && m_pend) begin
            m_ac_d = m_sh_d; m_ac_dp = m_sh_dp; m_ac_en = m_sh_en;
         end
         if (at_boundary) m_pend = 0;
         if (bus.load) begin
            m_sh_d = bus.data_in; m_sh_dp = bus.dp_in; m_sh_en = bus.en_in; m_pend = 1;
         end
         e_pend = m_pend;
         m_n++;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (bus.NA !== e_na || bus.SEG !== e_seg || bus.pending !== e_pend || bus.frame_done !== e_fd) begin
         errors++;
         $display("FAIL cycle n=%0d NA=%h want %h SEG=%h want %h pending=%b want %b frame_done=%b want %b",
                  m_n, bus.NA, e_na, bus.SEG, e_seg, bus.pending, e_pend, bus.frame_done, e_fd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int target);
      int guard = 0;
      while (m_n != target && guard < 1000) begin
         tick();
         guard++;
      end
      if (m_n != target) begin
         checks++;
         errors++;
         $display("FAIL goto got=%0d want=%0d", m_n, target);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
      bus.load = 1'b1; bus.data_in = d; bus.dp_in = dp; bus.en_in = en;
      tick();
      bus.load = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.en_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_na", bus.NA, 8'hFF);
      chk("reset_seg", bus.SEG, 8'hFF);
      chk("reset_pending", {7'b0, bus.pending}, 8'h00);

      goto(32); chk("fd_first", {7'b0, bus.frame_done}, 8'h01);
      goto(33); chk("fd_single", {7'b0, bus.frame_done}, 8'h00);
      goto(40); chk("dark_na", bus.NA, 8'hFF);

      goto(69); do_load(32'h89ABCDEF, 8'h01, 8'hFF);
      goto(95); chk("first_pending", {7'b0, bus.pending}, 8'h01);
      goto(96); chk("first_commit", {7'b0, bus.pending}, 8'h00);
      goto(97); chk("d0_blank_na", bus.NA, 8'hFF);
      goto(98); chk("d0_na", bus.NA, 8'hFE); chk("d0_seg", bus.SEG, 8'h0E);

      goto(100); do_load(32'h01234567, 8'h00, 8'h0F);
      goto(127); chk("d7_na", bus.NA, 8'h7F); chk("d7_seg", bus.SEG, 8'h80);
      goto(130); chk("mask_d0", bus.SEG, 8'hF8);
      goto(134); chk("mask_d1", bus.SEG, 8'h82);
      goto(138); chk("mask_d2", bus.SEG, 8'h92);
      goto(142); chk("mask_d3", bus.SEG, 8'h99); chk("mask_d3_na", bus.NA, 8'hF7);
      goto(146); chk("mask_d4_na", bus.NA, 8'hFF); chk("mask_d4_seg", bus.SEG, 8'hFF);

      goto(165); do_load(32'h11111111, 8'h00, 8'hFF);
      goto(170); do_load(32'h22222222, 8'h00, 8'hFF);
      goto(191); chk("lw_pending", {7'b0, bus.pending}, 8'h01);
      goto(192); chk("lw_cleared", {7'b0, bus.pending}, 8'h00);
      goto(194); chk("lw_d0", bus.SEG, 8'hA4);
      goto(222); chk("lw_d7", bus.SEG, 8'hA4); chk("lw_d7_na", bus.NA, 8'h7F);

      goto(255); do_load(32'h33333333, 8'h00, 8'hFF);
      chk("co_pending", {7'b0, bus.pending}, 8'h01);
      goto(258); chk("co_old", bus.SEG, 8'hA4);
      goto(288); chk("co_commit", {7'b0, bus.pending}, 8'h00);
      goto(290); chk("co_new", bus.SEG, 8'hB0);

      goto(301);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_na", bus.NA, 8'hFF);
      chk("mid_rst_seg", bus.SEG, 8'hFF);
      chk("mid_rst_pending", {7'b0, bus.pending}, 8'h00);
      repeat (3) tick();
      rst_n = 1'b1;
      goto(20); chk("post_rst_na", bus.NA, 8'hFF); chk("post_rst_seg", bus.SEG, 8'hFF);
      goto(31); chk("post_rst_fd0", {7'b0, bus.frame_done}, 8'h00);
      goto(32); chk("post_rst_fd1", {7'b0, bus.frame_done}, 8'h01);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Producer of the 8-bit SEG (cathode) and 8-bit NA (anode) pin buses that the FPGA top-level shell forwards to the board's 8-digit multiplexed 7-segment display.
- Accepts a 32-bit hex word plus per-digit decimal-point and enable masks from the CPU side through a load strobe.
- Latches the load into a shadow register and commits it tear-free at frame boundaries.
- Time-multiplexes the digits with a prescaler and applies an anti-ghosting blank window at the start of each digit slot.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot; legal range 2..2^24; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 64, cycles at the start of each slot during which all anodes are off; 0 disables blanking.

Ports:
- GlobalClock  in  1  system clock; all state is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe that captures data_in, dp_in and en_in.
- data_in  in  32  hex word; digit k shows data_in[4k+3:4k], digit 0 is rightmost.
- dp_in  in  8  decimal-point mask, bit k lights the DP of digit k.
- en_in  in  8  digit-enable mask; 0 blanks that digit.
- SEG  out  8  active-low cathodes; [0]=a .. [6]=g, [7]=dp.
- NA  out  8  active-low anodes, one-hot-low or all-high.
- pending  out  1  high while the shadow register holds an uncommitted load.
- frame_done  out  1  one-cycle pulse when digit 0 of a new frame begins.

Behaviour:
- Reset, asynchronous on RST_N low:
  - NA=8'hFF, SEG=8'hFF, pending=0, frame_done=0.
  - Prescaler cnt=0, digit index idx=0.
  - Shadow and active data, dp and en all cleared.
  - Display is dark until the first load is committed.
  - Asserting reset mid-frame forces these values immediately; the in-flight load is discarded.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - On each cnt==SCAN_DIV-1, idx advances 0..7 and wraps 7→0.
- Frame boundary is cnt==SCAN_DIV-1 && idx==7. On that edge:
  - If pending=1: active<=shadow, pending<=0.
  - frame_done<=1 for exactly one cycle, aligned with idx=0 / cnt=0.
- Load handling:
  - On load=1: shadow<=inputs, pending<=1.
  - Repeated loads in one frame overwrite the shadow (last wins); pending stays 1.
  - Load coincident with a boundary: the commit uses the pre-load shadow (only if pending was already 1), then the new value goes to the shadow with pending=1 and commits at the next boundary. Pending is therefore 1 after that edge.
- Output generation, registered (1-cycle latency from cnt/idx):
  - NA: all-high if cnt<BLANK_CYCLES or active_en[idx]==0; otherwise NA[idx]=0 and all other bits 1.
  - SEG[6:0] is the active-low hex decode of nibble idx; SEG[7]=~active_dp[idx].
  - SEG is 8'hFF whenever NA is all-high.
- Hex decode, SEG[6:0] as gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E.
- Arithmetic:
  - cnt is $clog2(SCAN_DIV) bits wide, idx is 3 bits.
  - All comparisons are unsigned, with no overflow beyond the wrap points.

Decomposition:
- Shared package holds NUM_DIGITS=8, the 16-entry hex-to-segment constant table, and the SEG/NA all-off constant 8'hFF.
- One combinational sub-module, hex7seg_decode (4-bit nibble in, 7-bit active-low segments out).
- Prescaler, commit logic and output registers stay in the top.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1):
- Reset: hold RST_N=0 for 3 cycles, release, run 40 cycles with no load → NA=FF, SEG=FF, pending=0, frame_done pulses every 32 cycles.
- First load: load 0x89ABCDEF, dp=01, en=FF at cycle 5 → pending=1 until the first boundary. In the following frame, digit-0 slot shows 1 cycle NA=FF then 3 cycles NA=FE, SEG=0E; digit-7 slot shows NA=7F, SEG=80.
- Blank mask: load 0x01234567, en=0F → digits 0-3 show 78, 02, 12, 19 (with SEG[7]=1). NA stays FF and SEG stays FF for all four slots of digits 4-7.
- Last-wins: load 0x11111111 then 0x22222222 in the same frame → next frame shows only 24 on all digits; pending clears on the boundary edge.
- Coincident load at boundary with pending=0 → that frame keeps the old value, pending=1, and the new value appears one frame (32 cycles) later.
- Mid-frame reset: drop RST_N during digit-3 slot → NA=FF, SEG=FF asynchronously. After release the display stays dark and idx restarts at 0.
